// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: mcause codes,
// mstatus bit positions, mtvec mode encodings and FSM state encodings.
package trap_ctrl_pkg;

    // mcause exception / interrupt codes
    localparam int M_SOFT  = 3;
    localparam int M_TIMER = 7;
    localparam int M_EXT   = 11;
    localparam int ECALL_M = 11;
    localparam int ILLEGAL = 2;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mie / mip bit positions
    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // mtvec mode encodings (modes 10 and 11 behave as direct)
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

endpackage

// File: rtl/trap_irq_arb.sv
// Machine interrupt arbiter: optional 2-flop synchronizer on the raw lines,
// masking by mie, and fixed-priority selection (ext > soft > timer).
// Optional feature macro: TRAP_CTRL_IRQ_SYNC_EN (synchronizer present).
module trap_irq_arb
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ECODE_W = 4
) (
`ifdef TRAP_CTRL_IRQ_SYNC_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic               irq_ext,
    input  logic               irq_soft,
    input  logic               irq_timer,
    input  logic [XLEN-1:0]    mie,
    input  logic               glb_mie,
    input  logic               commit_valid,
    input  logic               excp_req,
    input  logic               mret_req,
    output logic [XLEN-1:0]    mip_pend,
    output logic               irq_take,
    output logic [ECODE_W-1:0] irq_code
);

    // lines = {ext, timer, soft}
    logic [2:0] lines;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
    logic [2:0] sync_q1;
    logic [2:0] sync_q2;

    // Two-stage synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {irq_ext, irq_timer, irq_soft};
            sync_q2 <= sync_q1;
        end
    end

    assign lines = sync_q2;
`else
    assign lines = {irq_ext, irq_timer, irq_soft};
`endif

    logic [XLEN-1:0] line_vec;

    // Place the raw lines at their mip positions, then mask with mie
    always_comb begin
        line_vec           = '0;
        line_vec[MIP_MEIP] = lines[2];
        line_vec[MIP_MTIP] = lines[1];
        line_vec[MIP_MSIP] = lines[0];
    end

    assign mip_pend = line_vec & mie;

    // An interrupt only steals a clean commit slot with global MIE set
    assign irq_take = glb_mie && commit_valid && !excp_req && !mret_req &&
                      (mip_pend[MIP_MEIP] || mip_pend[MIP_MSIP] || mip_pend[MIP_MTIP]);

    // Fixed priority: external, then software, then timer
    always_comb begin
        irq_code = ECODE_W'(M_TIMER);
        if (mip_pend[MIP_MEIP])
            irq_code = ECODE_W'(M_EXT);
        else if (mip_pend[MIP_MSIP])
            irq_code = ECODE_W'(M_SOFT);
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret at
// commit, drives the CSR trap-entry/exit update bus, and redirects fetch over
// a valid/ready handshake while stalling the pipeline via trap_busy.
// Optional feature macro: TRAP_CTRL_IRQ_SYNC_EN (synchronize irq_* lines).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ECODE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [XLEN-1:0]    next_pc,
    input  logic               excp_req,
    input  logic [ECODE_W-1:0] excp_cause,
    input  logic [XLEN-1:0]    excp_tval,
    input  logic               mret_req,
    input  logic               irq_ext,
    input  logic               irq_soft,
    input  logic               irq_timer,
    input  logic [XLEN-1:0]    mstatus_rd_data,
    input  logic [XLEN-1:0]    mie_rd_data,
    input  logic [XLEN-1:0]    mtvec_rd_data,
    input  logic [XLEN-1:0]    mepc_rd_data,
    output logic               excp_enter,
    output logic               excp_exit,
    output logic [XLEN-1:0]    mstatus_wr_data,
    output logic [XLEN-1:0]    mepc_wr_data,
    output logic [XLEN-1:0]    mcause_wr_data,
    output logic [XLEN-1:0]    mtval_wr_data,
    output logic [XLEN-1:0]    mip_pend,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               redirect_ready,
    output logic               trap_busy
);

    trap_state_e state, state_nxt;

    logic               irq_take;
    logic [ECODE_W-1:0] irq_code;

    logic [ECODE_W-1:0] cap_cause;
    logic               cap_int;
    logic [XLEN-1:0]    cap_epc;
    logic [XLEN-1:0]    cap_tval;
    logic [XLEN-1:0]    redir_q;

    logic [XLEN-1:0]    enter_mstatus;
    logic [XLEN-1:0]    exit_mstatus;
    logic [XLEN-1:0]    mtvec_base;
    logic [XLEN-1:0]    enter_target;

    logic excp_win;
    logic mret_win;

    trap_irq_arb #(
        .XLEN    (XLEN),
        .ECODE_W (ECODE_W)
    ) u_irq_arb (
`ifdef TRAP_CTRL_IRQ_SYNC_EN
        .clk          (clk),
        .rst          (rst),
`endif
        .irq_ext      (irq_ext),
        .irq_soft     (irq_soft),
        .irq_timer    (irq_timer),
        .mie          (mie_rd_data),
        .glb_mie      (mstatus_rd_data[MSTATUS_MIE]),
        .commit_valid (commit_valid),
        .excp_req     (excp_req),
        .mret_req     (mret_req),
        .mip_pend     (mip_pend),
        .irq_take     (irq_take),
        .irq_code     (irq_code)
    );

    assign excp_win = commit_valid && excp_req;
    assign mret_win = commit_valid && mret_req;

    // mstatus images for trap entry and mret
    always_comb begin
        enter_mstatus                                = mstatus_rd_data;
        enter_mstatus[MSTATUS_MPIE]                  = mstatus_rd_data[MSTATUS_MIE];
        enter_mstatus[MSTATUS_MIE]                   = 1'b0;
        enter_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        exit_mstatus                                 = mstatus_rd_data;
        exit_mstatus[MSTATUS_MIE]                    = mstatus_rd_data[MSTATUS_MPIE];
        exit_mstatus[MSTATUS_MPIE]                   = 1'b1;
        exit_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    // Handler address: vectored mode offsets interrupts only
    always_comb begin
        mtvec_base   = mtvec_rd_data & ~XLEN'(3);
        enter_target = mtvec_base;
        if (mtvec_rd_data[1:0] == MTVEC_VECTORED && cap_int)
            enter_target = mtvec_base + (XLEN'(cap_cause) << 2);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and update-bus / redirect outputs
    always_comb begin
        state_nxt       = state;
        excp_enter      = 1'b0;
        excp_exit       = 1'b0;
        mstatus_wr_data = '0;
        mepc_wr_data    = '0;
        mcause_wr_data  = '0;
        mtval_wr_data   = '0;
        redirect_valid  = 1'b0;
        trap_busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (excp_win || irq_take)
                    state_nxt = ST_ENTER;
                else if (mret_win)
                    state_nxt = ST_EXIT;
            end
            ST_ENTER: begin
                excp_enter      = 1'b1;
                mstatus_wr_data = enter_mstatus;
                mepc_wr_data    = cap_epc & ~XLEN'(3);
                mcause_wr_data  = {cap_int, {(XLEN-1){1'b0}}} | XLEN'(cap_cause);
                mtval_wr_data   = cap_tval;
                state_nxt       = ST_REDIR;
            end
            ST_EXIT: begin
                excp_exit       = 1'b1;
                mstatus_wr_data = exit_mstatus;
                state_nxt       = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                if (redirect_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winning request; exceptions beat interrupts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_cause <= '0;
            cap_int   <= 1'b0;
            cap_epc   <= '0;
            cap_tval  <= '0;
        end else if (state == ST_IDLE) begin
            if (excp_win) begin
                cap_cause <= excp_cause;
                cap_int   <= 1'b0;
                cap_epc   <= commit_pc;
                cap_tval  <= excp_tval;
            end else if (irq_take) begin
                cap_cause <= irq_code;
                cap_int   <= 1'b1;
                cap_epc   <= next_pc;
                cap_tval  <= '0;
            end
        end
    end

    // Redirect target is latched in the strobe cycle and held through REDIR
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            redir_q <= '0;
        else if (state == ST_ENTER)
            redir_q <= enter_target;
        else if (state == ST_EXIT)
            redir_q <= mepc_rd_data;
    end

    assign redirect_pc = redir_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a timeline model (cycles since a request was accepted)
// checked every cycle, plus directed vectors with hand-computed values.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN    = 64;
    localparam int ECODE_W = 4;
`ifdef TRAP_CTRL_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               commit_valid = 1'b0;
    logic [XLEN-1:0]    commit_pc = '0;
    logic [XLEN-1:0]    next_pc = '0;
    logic               excp_req = 1'b0;
    logic [ECODE_W-1:0] excp_cause = '0;
    logic [XLEN-1:0]    excp_tval = '0;
    logic               mret_req = 1'b0;
    logic               irq_ext = 1'b0;
    logic               irq_soft = 1'b0;
    logic               irq_timer = 1'b0;
    logic [XLEN-1:0]    mstatus_rd_data = '0;
    logic [XLEN-1:0]    mie_rd_data = '0;
    logic [XLEN-1:0]    mtvec_rd_data = '0;
    logic [XLEN-1:0]    mepc_rd_data = '0;
    logic               excp_enter, excp_exit;
    logic [XLEN-1:0]    mstatus_wr_data, mepc_wr_data, mcause_wr_data, mtval_wr_data;
    logic [XLEN-1:0]    mip_pend;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               redirect_ready = 1'b0;
    logic               trap_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(XLEN), .ECODE_W(ECODE_W)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .next_pc(next_pc),
        .excp_req(excp_req), .excp_cause(excp_cause), .excp_tval(excp_tval),
        .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
        .mstatus_rd_data(mstatus_rd_data), .mie_rd_data(mie_rd_data),
        .mtvec_rd_data(mtvec_rd_data), .mepc_rd_data(mepc_rd_data),
        .excp_enter(excp_enter), .excp_exit(excp_exit),
        .mstatus_wr_data(mstatus_wr_data), .mepc_wr_data(mepc_wr_data),
        .mcause_wr_data(mcause_wr_data), .mtval_wr_data(mtval_wr_data),
        .mip_pend(mip_pend),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .trap_busy(trap_busy)
    );

    task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Interrupt lines as the design sees them (delayed when synchronized)
    logic [2:0] eff_irq;
`ifdef TRAP_CTRL_IRQ_SYNC_EN
    logic [2:0] bs1 = '0, bs2 = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin bs1 <= '0; bs2 <= '0; end
        else begin bs1 <= {irq_ext, irq_timer, irq_soft}; bs2 <= bs1; end
    end
    assign eff_irq = bs2;
`else
    assign eff_irq = {irq_ext, irq_timer, irq_soft};
`endif

    // Model: age 0 = idle, 1 = strobe cycle, >=2 = redirect offered
    int               age = 0;
    logic             m_exit = 1'b0, m_int = 1'b0;
    logic [XLEN-1:0]  m_cause = '0, m_epc = '0, m_tval = '0, m_tgt = '0;

    always @(negedge clk) begin
        logic [XLEN-1:0] e_mip, e_ms, e_mepc, e_mcause, e_mtval, base;
        if (rst) age = 0;
        e_mip = '0;
        e_mip[11] = eff_irq[2] & mie_rd_data[11];
        e_mip[7]  = eff_irq[1] & mie_rd_data[7];
        e_mip[3]  = eff_irq[0] & mie_rd_data[3];
        e_ms = '0; e_mepc = '0; e_mcause = '0; e_mtval = '0;
        if (age == 1 && !m_exit) begin
            e_ms     = (mstatus_rd_data & ~64'h1888) | (mstatus_rd_data[3] ? 64'h80 : 64'h0) | 64'h1800;
            e_mepc   = (m_epc / 4) * 4;
            e_mcause = (m_int ? 64'h8000_0000_0000_0000 : 64'h0) + m_cause;
            e_mtval  = m_tval;
        end else if (age == 1) begin
            e_ms = (mstatus_rd_data & ~64'h1888) | (mstatus_rd_data[7] ? 64'h8 : 64'h0) | 64'h1880;
        end
        cmp("m_busy", trap_busy, (age != 0));
        cmp("m_enter", excp_enter, (age == 1 && !m_exit));
        cmp("m_exit", excp_exit, (age == 1 && m_exit));
        cmp("m_mstatus", mstatus_wr_data, e_ms);
        cmp("m_mepc", mepc_wr_data, e_mepc);
        cmp("m_mcause", mcause_wr_data, e_mcause);
        cmp("m_mtval", mtval_wr_data, e_mtval);
        cmp("m_mip", mip_pend, e_mip);
        cmp("m_rvalid", redirect_valid, (age >= 2));
        if (age >= 2) cmp("m_rpc", redirect_pc, m_tgt);
        if (rst) cmp("m_rpc_rst", redirect_pc, 64'h0);
        if (!rst) begin
            if (age == 0) begin
                if (commit_valid && excp_req) begin
                    m_exit = 0; m_int = 0; m_cause = XLEN'(excp_cause);
                    m_epc = commit_pc; m_tval = excp_tval; age = 1;
                end else if (commit_valid && !mret_req && mstatus_rd_data[3] && (e_mip != 0)) begin
                    m_exit = 0; m_int = 1;
                    m_cause = e_mip[11] ? 64'd11 : (e_mip[3] ? 64'd3 : 64'd7);
                    m_epc = next_pc; m_tval = 0; age = 1;
                end else if (commit_valid && mret_req) begin
                    m_exit = 1; age = 1;
                end
            end else if (age == 1) begin
                base = (mtvec_rd_data / 4) * 4;
                if (m_exit) m_tgt = mepc_rd_data;
                else if (mtvec_rd_data[1:0] == 2'b01 && m_int) m_tgt = base + 4 * m_cause;
                else m_tgt = base;
                age = 2;
            end else if (redirect_ready) begin
                age = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clr_req();
        commit_valid = 0; excp_req = 0; mret_req = 0;
    endtask

    task automatic settle();
        repeat (SYNC_LAT + 1) step();
    endtask

    initial begin
        // Reset state
        step(); step();
        cmp("rst_busy", trap_busy, 1'b0);
        cmp("rst_rvalid", redirect_valid, 1'b0);
        cmp("rst_rpc", redirect_pc, 64'h0);
        cmp("rst_enter", excp_enter, 1'b0);
        rst = 0;
        step();

        // Ecall, direct mtvec
        mtvec_rd_data = 64'h8000_0100; mstatus_rd_data = 64'h8; redirect_ready = 1;
        commit_valid = 1; excp_req = 1; excp_cause = ECODE_W'(ECALL_M);
        commit_pc = 64'h8000_0042; excp_tval = 64'h123;
        step(); clr_req();
        cmp("ecall_enter", excp_enter, 1'b1);
        cmp("ecall_mepc", mepc_wr_data, 64'h8000_0040);
        cmp("ecall_mcause", mcause_wr_data, 64'd11);
        cmp("ecall_mstatus", mstatus_wr_data, 64'h1880);
        cmp("ecall_mtval", mtval_wr_data, 64'h123);
        step();
        cmp("ecall_rvalid", redirect_valid, 1'b1);
        cmp("ecall_rpc", redirect_pc, 64'h8000_0100);
        step();
        cmp("ecall_idle", trap_busy, 1'b0);

        // Vectored timer interrupt
        mtvec_rd_data = 64'h8000_0101; mie_rd_data = 64'h80; irq_timer = 1;
        settle();
        commit_valid = 1; next_pc = 64'h8000_0010;
        step(); clr_req(); irq_timer = 0;
        cmp("tmr_mcause", mcause_wr_data, 64'h8000_0000_0000_0007);
        cmp("tmr_mepc", mepc_wr_data, 64'h8000_0010);
        cmp("tmr_mtval", mtval_wr_data, 64'h0);
        step();
        cmp("tmr_rpc", redirect_pc, 64'h8000_011C);
        step(); settle();

        // Masked by mstatus.MIE = 0
        mstatus_rd_data = 64'h0; mie_rd_data = 64'h888;
        irq_ext = 1; irq_soft = 1; irq_timer = 1;
        settle();
        commit_valid = 1;
        step();
        cmp("mask_enter", excp_enter, 1'b0);
        cmp("mask_busy", trap_busy, 1'b0);
        cmp("mask_mip", mip_pend, 64'h888);
        clr_req(); irq_soft = 0; irq_timer = 0;

        // Exception beats simultaneous external interrupt
        mstatus_rd_data = 64'h8; mie_rd_data = 64'h800; mtvec_rd_data = 64'h8000_0100;
        settle();
        commit_valid = 1; excp_req = 1; excp_cause = ECODE_W'(ILLEGAL);
        commit_pc = 64'h8000_0200; excp_tval = 64'hDEAD;
        step(); clr_req();
        cmp("sim_mcause", mcause_wr_data, 64'd2);
        step(); step();

        // mret
        mstatus_rd_data = 64'h80; mepc_rd_data = 64'h8000_0044;
        commit_valid = 1; mret_req = 1;
        step(); clr_req();
        cmp("mret_exit", excp_exit, 1'b1);
        cmp("mret_mstatus", mstatus_wr_data, 64'h1888);
        cmp("mret_mcause", mcause_wr_data, 64'h0);
        step();
        cmp("mret_rpc", redirect_pc, 64'h8000_0044);
        step();

        // Pending external interrupt taken once MIE is back
        mstatus_rd_data = 64'h1888; commit_valid = 1; next_pc = 64'h8000_0048;
        step(); clr_req(); irq_ext = 0;
        cmp("ext_mcause", mcause_wr_data, 64'h8000_0000_0000_000B);
        cmp("ext_mepc", mepc_wr_data, 64'h8000_0048);
        step(); step(); settle();

        // Backpressure, with ignored requests while busy
        redirect_ready = 0; mstatus_rd_data = 64'h8;
        commit_valid = 1; excp_req = 1; excp_cause = ECODE_W'(ECALL_M); commit_pc = 64'h8000_0300;
        step(); clr_req();
        step();
        commit_valid = 1; excp_req = 1; excp_cause = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("bp_rvalid", redirect_valid, 1'b1);
            cmp("bp_rpc", redirect_pc, 64'h8000_0100);
        end
        clr_req(); redirect_ready = 1;
        step();
        cmp("bp_done", trap_busy, 1'b0);

        // Reset mid-REDIR
        redirect_ready = 0;
        commit_valid = 1; excp_req = 1; commit_pc = 64'h8000_0400;
        step(); clr_req();
        step();
        cmp("pre_rst_rvalid", redirect_valid, 1'b1);
        rst = 1; #1;
        cmp("arst_rvalid", redirect_valid, 1'b0);
        cmp("arst_busy", trap_busy, 1'b0);
        cmp("arst_rpc", redirect_pc, 64'h0);
        step(); rst = 0;
        step(); step();
        cmp("post_rst_busy", trap_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer for the machine-mode CSR file. Arbitrates synchronous exceptions, machine interrupts (external/software/timer) and mret at the commit point. Drives the CSR file's excp_enter/excp_exit update bus (mstatus, mepc, mcause, mtval). Issues a PC redirect to fetch over a valid/ready handshake, and stalls the pipeline while a trap is in flight.

Parameters:
XLEN, 64, data/PC width
ECODE_W, 4, exception code width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
commit_valid  in  1  an instruction is retiring this cycle
commit_pc  in  XLEN  PC of the retiring instruction
next_pc  in  XLEN  PC of the instruction after the retiring one
excp_req  in  1  retiring instruction raised an exception
excp_cause  in  ECODE_W  exception code
excp_tval  in  XLEN  trap value
mret_req  in  1  retiring instruction is mret
irq_ext / irq_soft / irq_timer  in  1 each  raw interrupt lines (MEIP/MSIP/MTIP)
mstatus_rd_data / mie_rd_data / mtvec_rd_data / mepc_rd_data  in  XLEN  live CSR values
excp_enter / excp_exit  out  1  CSR trap-entry / trap-exit update strobes
mstatus_wr_data / mepc_wr_data / mcause_wr_data / mtval_wr_data  out  XLEN  CSR update values
mip_pend  out  XLEN  pending bits (3, 7, 11) for MIP mirroring
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  redirect target
redirect_ready  in  1  fetch accepts the redirect
trap_busy  out  1  stall the pipeline; high whenever state != IDLE

Behaviour:
- States: IDLE, ENTER, EXIT, REDIR. Reset state is IDLE. All outputs reset to 0.
- Reset is asynchronous. Asserting rst in any state returns to IDLE immediately and drops redirect_valid.
- Interrupt qualification: pend = {irq_ext, irq_timer, irq_soft} & mie_rd_data bits {11, 7, 3}.
- An interrupt is taken only when mstatus.MIE (bit 3) = 1, commit_valid = 1, excp_req = 0 and mret_req = 0.
- Interrupt priority: ext (code 11) > soft (3) > timer (7).
- IDLE priority: excp_req > interrupt > mret_req, all gated by commit_valid.
- The winning request is captured into registers: cause, is_int, epc, tval.
  - Exception: epc = commit_pc, tval = excp_tval.
  - Interrupt: epc = next_pc, tval = 0.
- Exception or interrupt: IDLE -> ENTER. mret: IDLE -> EXIT.
- ENTER (exactly 1 cycle):
  - excp_enter = 1.
  - mstatus_wr_data = mstatus_rd_data with MPIE(7) <= MIE(3), MIE <= 0, MPP[12:11] <= 2'b11.
  - mepc_wr_data = {epc[XLEN-1:2], 2'b00}.
  - mcause_wr_data = {is_int, zero-extended cause}.
  - mtval_wr_data = tval.
  - redirect_pc is registered as follows: if mtvec[1:0] = 01 and is_int, {mtvec[XLEN-1:2], 2'b00} + 4*cause; otherwise {mtvec[XLEN-1:2], 2'b00}. Modes 10 and 11 are treated as direct.
  - Next state: REDIR.
- EXIT (exactly 1 cycle):
  - excp_exit = 1.
  - mstatus_wr_data: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
  - redirect_pc <= mepc_rd_data. Next state: REDIR.
- Update-bus outputs are 0 when neither strobe is asserted.
- REDIR: redirect_valid = 1. redirect_pc is held stable until redirect_ready. On the handshake cycle, transition to IDLE.
- Latency: request in cycle N; CSR strobe in N+1; redirect_valid from N+2. Minimum 3 cycles IDLE-to-IDLE.
- Requests arriving while not IDLE are ignored; the pipeline is held by trap_busy. mip_pend is live in every state.

Optional Feature:
TRAP_CTRL_IRQ_SYNC_EN
- Defined: each irq_* line passes through a 2-flop synchronizer (flops reset to 0) before qualification. Interrupt recognition latency increases by 2 cycles.
- Undefined: lines are used combinationally and are assumed synchronous to clk.

Decomposition:
- Shared defines file:
  - mcause codes (M_SOFT = 3, M_TIMER = 7, M_EXT = 11, ECALL_M = 11, ILLEGAL = 2)
  - mstatus bit positions (MIE = 3, MPIE = 7, MPP = 12:11)
  - mtvec mode encodings
  - FSM state encodings
- One sub-module: trap_irq_arb. It holds the optional synchronizer, the pend masking, and the priority encoder producing irq_take and irq_code.

Test Plan:
- Ecall: mtvec = 0x8000_0100, excp_req, cause 11, commit_pc = 0x8000_0042, ready = 1 -> excp_enter at N+1, mepc = 0x8000_0040, mcause = 11, mstatus MIE 1 -> 0 / MPIE = 1; redirect 0x8000_0100 at N+2.
- Vectored timer interrupt: mtvec = 0x8000_0101, MIE = 1, mie = 0x80, irq_timer, next_pc = 0x8000_0010 -> mcause = 0x8000_0000_0000_0007, mepc = 0x8000_0010, mtval = 0, redirect 0x8000_011C.
- Masking: MIE = 0 with all irq lines high -> no excp_enter, trap_busy = 0, mip_pend = 0x888 (mie = 0x888).
- Simultaneous excp_req (cause 2) and irq_ext with MIE = 1 -> exception taken, mcause = 2; the interrupt is taken on a later commit after mret.
- mret: mepc = 0x8000_0044, mstatus = 0x80 -> excp_exit, mstatus_wr_data = 0x1888, redirect 0x8000_0044.
- Backpressure and reset: redirect_ready low for 3 cycles -> redirect_valid and redirect_pc held. rst pulsed mid-REDIR -> immediately IDLE, all outputs 0.
